cnn_run_sequencer: RTL and testbench
====================================

Name: cnn_run_sequencer

Overview:
- Synthesisable run controller that drives the CNN top (`main`) through repeated inference runs.
- Per run: pulses the DUT reset, waits, raises startFlag, holds it until `done`, and records latency.
- Replaces the fixed one-shot bench stimulus with parametrised run count, hold and delay lengths, a timeout watchdog and latency reporting.
- Instantiated in the bench or an on-board harness between the clock/reset source and `main`.

Parameters:
- RST_HOLD_CYCLES, 10, cycles dut_rst_n is held low per run (>=1)
- START_DELAY_CYCLES, 10, cycles from dut_rst_n release to start_flag rise (>=1)
- NUM_RUNS, 4, runs per go command (>=1)
- TIMEOUT_CYCLES, 100000, max cycles start_flag may stay high without done (>=1)
- CNT_W, 32, width of latency/cycle counters (must hold TIMEOUT_CYCLES)
- RUN_W, 8, width of run index (must hold NUM_RUNS)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- go  in  1  level; sampled only in IDLE, starts a NUM_RUNS sequence
- done  in  1  from DUT, completion flag
- dut_rst_n  out  1  active-low reset to DUT
- start_flag  out  1  to DUT startFlag
- busy  out  1  high in any state except IDLE
- run_idx  out  RUN_W  index of current/last run, 0-based
- last_latency  out  CNT_W  cycles from start_flag rise to done seen, last completed run
- latency_valid  out  1  one-cycle pulse when last_latency updates
- all_done  out  1  high in IDLE after a sequence completed without error; cleared on next go
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by rst

Behaviour:
- Single clock; all state and outputs registered; rst (async, active-low) applies reset values immediately.
- Reset values: dut_rst_n=0, start_flag=0, busy=0, run_idx=0, last_latency=0, latency_valid=0, all_done=0, timeout_err=0, state=IDLE.
- FSM states: IDLE, HOLD_RST, DELAY, RUN, DRAIN, ERROR.
- IDLE: dut_rst_n=0.
  - go=1 and timeout_err=0 -> HOLD_RST next cycle; run_idx<=0, all_done<=0, counter<=0.
  - go=1 while timeout_err=1 is ignored.
- HOLD_RST: dut_rst_n=0 for exactly RST_HOLD_CYCLES cycles, then -> DELAY with dut_rst_n<=1.
- DELAY: exactly START_DELAY_CYCLES cycles, then -> RUN with start_flag<=1 and latency counter<=0.
- RUN: counter increments each cycle while done=0.
  - done=1 sampled: start_flag<=0, last_latency<=counter+1, latency_valid pulses, -> DRAIN. Deassert latency is one cycle after done.
  - counter+1 == TIMEOUT_CYCLES with done still 0: start_flag<=0, dut_rst_n<=0, timeout_err<=1, -> ERROR.
  - done and timeout on the same cycle: done wins.
- DRAIN: waits for done=0, so the next run cannot see a stale done.
  - done=0 and run_idx==NUM_RUNS-1 -> IDLE with all_done<=1.
  - otherwise run_idx<=run_idx+1, -> HOLD_RST (dut_rst_n<=0).
- ERROR: dut_rst_n=0, start_flag=0, busy=1; exits only via rst.
- done=1 in IDLE, HOLD_RST or DELAY is ignored.
- Counters saturate and never wrap.
- rst asserted mid-run: all state returns to reset values; DUT is held in reset by dut_rst_n=0.
- go held high continuously restarts a new sequence on the cycle after all_done sets.

Optional Feature:
- Macro: CNN_SEQ_LATENCY_STATS_EN.
- Defined: adds outputs min_latency and max_latency (CNT_W each).
  - Reset values: min=all-ones, max=0.
  - Both cleared to those values on each accepted go.
  - Updated on every latency_valid.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package cnn_seq_pkg: state enum (IDLE..ERROR) and a default-parameter constants block.
- One natural sub-module: cnn_seq_sat_counter, a saturating up-counter with clear and enable. Instantiated for both the phase counter and the latency counter.

Test Plan:
- rst low 10 cycles, go=1, DUT model raises done 50 cycles after start_flag (NUM_RUNS=4) -> four dut_rst_n pulses of exactly 10 cycles; start_flag rises 10 cycles after each release; last_latency=50 four times; all_done=1; run_idx=3.
- TIMEOUT_CYCLES=20, done never rises -> timeout_err=1 exactly 20 cycles after start_flag rise; start_flag=0; dut_rst_n=0; subsequent go ignored until rst.
- done held high 5 extra cycles after the start_flag drop -> sequencer stays in DRAIN and does not re-enter HOLD_RST until done=0; no double latency_valid.
- rst asserted during RUN at latency 30 -> all outputs at reset values asynchronously; go afterward starts run 0 cleanly.
- done=1 arriving on exactly the timeout cycle -> latency recorded as TIMEOUT_CYCLES, no timeout_err.
- With CNN_SEQ_LATENCY_STATS_EN, latencies 40, 25, 60, 30 -> min_latency=25, max_latency=60.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared state encoding and default timing constants
// for the CNN run sequencer.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_RST,
        DELAY,
        RUN,
        DRAIN,
        ERROR
    } seq_state_e;

    localparam int unsigned DEF_RST_HOLD_CYCLES    = 10;
    localparam int unsigned DEF_START_DELAY_CYCLES = 10;
    localparam int unsigned DEF_NUM_RUNS           = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 100000;
    localparam int unsigned DEF_CNT_W              = 32;
    localparam int unsigned DEF_RUN_W              = 8;

    // Phases timed by the shared phase counter
    function automatic logic in_phase(input seq_state_e s);
        return (s == HOLD_RST) || (s == DELAY);
    endfunction

endpackage

// File: rtl/cnn_seq_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module cnn_seq_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cnn_run_sequencer.sv
// Run controller: resets, starts and times repeated CNN inference runs.
// Define CNN_SEQ_LATENCY_STATS_EN to add min/max latency outputs.
module cnn_run_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int unsigned START_DELAY_CYCLES = DEF_START_DELAY_CYCLES,
    parameter int unsigned NUM_RUNS           = DEF_NUM_RUNS,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W              = DEF_CNT_W,
    parameter int unsigned RUN_W              = DEF_RUN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             done,
    output logic             dut_rst_n,
    output logic             start_flag,
    output logic             busy,
    output logic [RUN_W-1:0] run_idx,
    output logic [CNT_W-1:0] last_latency,
    output logic             latency_valid,
    output logic             all_done,
    output logic             timeout_err
`ifdef CNN_SEQ_LATENCY_STATS_EN
    ,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency
`endif
);

    seq_state_e state_q, state_d;

    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_next;
    logic phase_clr, phase_en;
    logic lat_clr, lat_en;
    logic accept, hold_end, delay_end;
    logic tmo_hit, last_run, lat_hit;

    logic             dut_rst_n_q, dut_rst_n_d;
    logic             start_flag_q, start_flag_d;
    logic             busy_q, busy_d;
    logic [RUN_W-1:0] run_idx_q, run_idx_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;
    logic             lat_valid_q, lat_valid_d;
    logic             all_done_q, all_done_d;
    logic             terr_q, terr_d;

    assign accept    = (state_q == IDLE) && go && !terr_q;
    assign hold_end  = phase_cnt == CNT_W'(RST_HOLD_CYCLES - 1);
    assign delay_end = phase_cnt == CNT_W'(START_DELAY_CYCLES - 1);
    assign tmo_hit   = lat_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign last_run  = run_idx_q == RUN_W'(NUM_RUNS - 1);
    assign lat_hit   = (state_q == RUN) && done;
    assign lat_next  = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;

    // Phase counter restarts on every state change
    assign phase_en  = in_phase(state_q);
    assign phase_clr = !phase_en || (state_d != state_q);
    assign lat_en    = (state_q == RUN);
    assign lat_clr   = !lat_en;

    cnn_seq_sat_counter #(.W(CNT_W)) u_phase_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (phase_clr),
        .en_i   (phase_en),
        .cnt_o  (phase_cnt)
    );

    cnn_seq_sat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (lat_clr),
        .en_i   (lat_en),
        .cnt_o  (lat_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dut_rst_n_q  <= 1'b0;
            start_flag_q <= 1'b0;
            busy_q       <= 1'b0;
            run_idx_q    <= '0;
            last_lat_q   <= '0;
            lat_valid_q  <= 1'b0;
            all_done_q   <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dut_rst_n_q  <= dut_rst_n_d;
            start_flag_q <= start_flag_d;
            busy_q       <= busy_d;
            run_idx_q    <= run_idx_d;
            last_lat_q   <= last_lat_d;
            lat_valid_q  <= lat_valid_d;
            all_done_q   <= all_done_d;
            terr_q       <= terr_d;
        end
    end

    // A done coinciding with the timeout cycle counts as completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (accept) state_d = HOLD_RST;
            HOLD_RST: if (hold_end) state_d = DELAY;
            DELAY:    if (delay_end) state_d = RUN;
            RUN: begin
                if (done) begin
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    state_d = ERROR;
                end
            end
            DRAIN: begin
                if (!done) begin
                    state_d = last_run ? IDLE : HOLD_RST;
                end
            end
            ERROR:    state_d = ERROR;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        dut_rst_n_d  = (state_d == DELAY) || (state_d == RUN) ||
                       (state_d == DRAIN);
        start_flag_d = (state_d == RUN);
        busy_d       = (state_d != IDLE);
        lat_valid_d  = lat_hit;
        last_lat_d   = lat_hit ? lat_next : last_lat_q;
        terr_d       = terr_q || ((state_q == RUN) && (state_d == ERROR));
        run_idx_d    = run_idx_q;
        all_done_d   = all_done_q;
        if (accept) begin
            run_idx_d  = '0;
            all_done_d = 1'b0;
        end else if (state_q == DRAIN) begin
            if (state_d == HOLD_RST) begin
                run_idx_d = run_idx_q + 1'b1;
            end
            if (state_d == IDLE) begin
                all_done_d = 1'b1;
            end
        end
    end

    assign dut_rst_n     = dut_rst_n_q;
    assign start_flag    = start_flag_q;
    assign busy          = busy_q;
    assign run_idx       = run_idx_q;
    assign last_latency  = last_lat_q;
    assign latency_valid = lat_valid_q;
    assign all_done      = all_done_q;
    assign timeout_err   = terr_q;

`ifdef CNN_SEQ_LATENCY_STATS_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (accept) begin
            min_d = '1;
            max_d = '0;
        end else if (lat_hit) begin
            if (lat_next < min_q) min_d = lat_next;
            if (lat_next > max_q) max_d = lat_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_latency = min_q;
    assign max_latency = max_q;
`endif

endmodule

// File: tb/tb_cnn_run_sequencer.sv
// Directed bench for cnn_run_sequencer: table of run sequences
// plus drain, reset-abort and watchdog sequences.
module tb_cnn_run_sequencer;

    localparam int CW = 32;
    localparam int RW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CW-1:0] ones = '1;

    logic a_rst, a_gos, a_done = 1'b0;
    logic a_drst, a_sf, a_busy, a_lv, a_ad, a_te;
    logic [RW-1:0] a_ridx;
    logic [CW-1:0] a_lat;
    logic b_rst, b_gos, b_done = 1'b0;
    logic b_drst, b_sf, b_busy, b_lv, b_ad, b_te;
    logic [RW-1:0] b_ridx;
    logic [CW-1:0] b_lat;
`ifdef CNN_SEQ_LATENCY_STATS_EN
    logic [CW-1:0] a_min, a_max, b_min, b_max;
`endif

    cnn_run_sequencer u_a (
        .clk           (clk),
        .rst           (a_rst),
        .go            (a_gos),
        .done          (a_done),
        .dut_rst_n     (a_drst),
        .start_flag    (a_sf),
        .busy          (a_busy),
        .run_idx       (a_ridx),
        .last_latency  (a_lat),
        .latency_valid (a_lv),
        .all_done      (a_ad),
        .timeout_err   (a_te)
`ifdef CNN_SEQ_LATENCY_STATS_EN
        ,
        .min_latency   (a_min),
        .max_latency   (a_max)
`endif
    );

    cnn_run_sequencer #(
        .RST_HOLD_CYCLES    (3),
        .START_DELAY_CYCLES (2),
        .NUM_RUNS           (1),
        .TIMEOUT_CYCLES     (20)
    ) u_b (
        .clk           (clk),
        .rst           (b_rst),
        .go            (b_gos),
        .done          (b_done),
        .dut_rst_n     (b_drst),
        .start_flag    (b_sf),
        .busy          (b_busy),
        .run_idx       (b_ridx),
        .last_latency  (b_lat),
        .latency_valid (b_lv),
        .all_done      (b_ad),
        .timeout_err   (b_te)
`ifdef CNN_SEQ_LATENCY_STATS_EN
        ,
        .min_latency   (b_min),
        .max_latency   (b_max)
`endif
    );

    // CNN model A: done rises a_tgt cycles after start_flag,
    // lingers a_extra cycles after start_flag drops
    int a_cnt = 0, a_xt = 0, a_runs = 0, a_extra = 0;
    int a_tgt [8];
    always @(negedge clk) begin
        if (!a_busy) a_runs = 0;
        if (!a_drst) begin
            a_cnt = 0; a_done = 1'b0; a_xt = 0;
        end else if (a_sf) begin
            a_cnt++;
            if (a_cnt == a_tgt[a_runs[2:0]]) a_done = 1'b1;
        end else if (a_done) begin
            if (a_xt >= a_extra) begin
                a_done = 1'b0; a_runs++;
            end else begin
                a_xt++;
            end
        end
    end

    // CNN model B: b_tgt == 0 means done never rises
    int b_cnt = 0, b_tgt = 0;
    always @(negedge clk) begin
        if (!b_drst) begin
            b_cnt = 0; b_done = 1'b0;
        end else if (b_sf) begin
            b_cnt++;
            if (b_cnt == b_tgt) b_done = 1'b1;
        end else begin
            b_done = 1'b0;
        end
    end

    typedef struct packed {
        logic [3:0][15:0] lat;
        logic [7:0]       extra;
        logic [3:0][15:0] exp_lat;
        logic [15:0]      exp_min;
        logic [15:0]      exp_max;
    } vec_t;

    vec_t vecs [3];

    function automatic vec_t mk(input int l0, l1, l2, l3, ex,
                                input int e0, e1, e2, e3, mn, mx);
        vec_t v;
        v.lat[0] = 16'(l0); v.lat[1] = 16'(l1);
        v.lat[2] = 16'(l2); v.lat[3] = 16'(l3);
        v.extra = 8'(ex);
        v.exp_lat[0] = 16'(e0); v.exp_lat[1] = 16'(e1);
        v.exp_lat[2] = 16'(e2); v.exp_lat[3] = 16'(e3);
        v.exp_min = 16'(mn); v.exp_max = 16'(mx);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int vi, input bit hold_go);
        int lowc, dly, gap, nlv;
        bit darm, garm, seen;
        logic pd, ps;
        lowc = 0; dly = 0; gap = 0; nlv = 0;
        darm = 0; garm = 0; seen = 0;
        a_extra = int'(vecs[vi].extra);
        for (int r = 0; r < 4; r++) a_tgt[r] = int'(vecs[vi].lat[r]);
        pd = a_drst; ps = a_sf;
        a_gos = 1'b1;
        for (int c = 0; c < 3000 && !seen; c++) begin
            tick();
            if (!hold_go) a_gos = 1'b0;
            if (a_busy && !a_drst) lowc++;
            if (a_drst && !pd) begin
                chk("rst_low_len", lowc, 10);
                lowc = 0; darm = 1; dly = 0;
            end
            if (darm && !a_sf) dly++;
            if (a_sf && !ps) begin
                chk("start_delay", dly, 10);
                darm = 0;
            end
            if (garm) gap++;
            if (!a_sf && ps) begin
                garm = 1; gap = 0;
            end
            if (!a_drst && pd && a_busy) begin
                chk("drain_gap", gap, 1 + int'(vecs[vi].extra));
                garm = 0;
            end
            if (a_lv) begin
                if (nlv < 4) chk("latency", a_lat, vecs[vi].exp_lat[nlv]);
                nlv++;
            end
            if (a_ad) begin
                seen = 1;
                chk("last_drain_gap", gap, 1 + int'(vecs[vi].extra));
            end
            pd = a_drst; ps = a_sf;
        end
        if (!seen) chk("seq_timeout", 0, 1);
        chk("lv_pulses", nlv, 4);
        chk("run_idx_end", a_ridx, 3);
        chk("busy_end", a_busy, 0);
        chk("err_end", a_te, 0);
`ifdef CNN_SEQ_LATENCY_STATS_EN
        chk("min_latency", a_min, vecs[vi].exp_min);
        chk("max_latency", a_max, vecs[vi].exp_max);
`endif
        if (hold_go) begin
            tick();
            chk("restart_busy", a_busy, 1);
            chk("restart_all_done", a_ad, 0);
            chk("restart_run_idx", a_ridx, 0);
`ifdef CNN_SEQ_LATENCY_STATS_EN
            chk("restart_min", a_min, ones);
            chk("restart_max", a_max, 0);
`endif
        end
    endtask

    task automatic chk_a_reset(input string pfx);
        chk({pfx, "_drst"}, a_drst, 0);
        chk({pfx, "_sf"}, a_sf, 0);
        chk({pfx, "_busy"}, a_busy, 0);
        chk({pfx, "_ridx"}, a_ridx, 0);
        chk({pfx, "_lat"}, a_lat, 0);
        chk({pfx, "_lv"}, a_lv, 0);
        chk({pfx, "_ad"}, a_ad, 0);
        chk({pfx, "_te"}, a_te, 0);
`ifdef CNN_SEQ_LATENCY_STATS_EN
        chk({pfx, "_min"}, a_min, ones);
        chk({pfx, "_max"}, a_max, 0);
`endif
    endtask

    initial begin
        int k, hi;
        bit hit;
        vecs[0] = mk(50, 50, 50, 50, 0, 50, 50, 50, 50, 50, 50);
        vecs[1] = mk(40, 25, 60, 30, 0, 40, 25, 60, 30, 25, 60);
        vecs[2] = mk(7, 3, 12, 1, 5, 7, 3, 12, 1, 1, 12);
        for (int i = 0; i < 8; i++) a_tgt[i] = 0;

        a_rst = 1'b0; b_rst = 1'b0; a_gos = 1'b0; b_gos = 1'b0;
        repeat (10) tick();
        chk_a_reset("reset");
        chk("reset_b_drst", b_drst, 0);
        chk("reset_b_te", b_te, 0);
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 3; v++) begin
            run_seq(v, 1'b0);
            repeat (3) tick();
        end

        // go held high restarts, then reset aborts the run mid-flight
        run_seq(0, 1'b1);
        a_gos = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            tick();
            if (a_sf) hit = 1;
        end
        chk("abort_start_seen", hit, 1);
        repeat (29) tick();
        #2 a_rst = 1'b0;
        #1 chk_a_reset("async_rst");
        #10 a_rst = 1'b1;
        repeat (2) tick();
        run_seq(1, 1'b0);

        // done on exactly the watchdog cycle counts as completion
        b_tgt = 20;
        b_gos = 1'b1; tick(); b_gos = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (b_lv) hit = 1; else tick();
        end
        chk("b_edge_lv_seen", hit, 1);
        chk("b_edge_latency", b_lat, 20);
        chk("b_edge_no_err", b_te, 0);
        repeat (3) tick();
        chk("b_edge_all_done", b_ad, 1);

        // watchdog expiry
        b_tgt = 0;
        b_gos = 1'b1; tick(); b_gos = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (b_sf) hit = 1; else tick();
        end
        chk("b_tmo_start_seen", hit, 1);
        k = 0;
        for (int c = 0; c < 100 && !b_te; c++) begin
            tick();
            k++;
        end
        chk("b_tmo_cycles", k, 20);
        chk("b_tmo_sf", b_sf, 0);
        chk("b_tmo_drst", b_drst, 0);
        chk("b_tmo_busy", b_busy, 1);
        chk("b_tmo_lv", b_lv, 0);
        b_gos = 1'b1;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (b_drst || b_sf || !b_te) hi++;
        end
        b_gos = 1'b0;
        chk("b_err_ignores_go", hi, 0);
        #3 b_rst = 1'b0;
        #1 chk("b_rst_clears_err", b_te, 0);
        chk("b_rst_busy", b_busy, 0);
        #10 b_rst = 1'b1;
        tick();
        b_tgt = 5;
        b_gos = 1'b1; tick(); b_gos = 1'b0;
        for (int c = 0; c < 100 && !b_ad; c++) tick();
        chk("b_recover_all_done", b_ad, 1);
        chk("b_recover_latency", b_lat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
